// File: rtl/vending_controller_pkg.sv
// ============================================================================
// Module      : vending_controller_pkg
// Description : Shared vending-machine definitions: sizes, coin/price tables,
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vending_controller_pkg;

    localparam int C_NUM_COINS  = 3;
    localparam int C_NUM_ITEMS  = 4;
    localparam int C_TOTAL_BITS = 31;

    typedef logic [C_TOTAL_BITS-1:0] total_t;

    // Coin denominations must stay in ascending order; the greedy picker relies on it
    localparam total_t C_COIN_VALUE [C_NUM_COINS] = '{
        total_t'(100), total_t'(500), total_t'(1000)
    };

    localparam total_t C_PRICE [C_NUM_ITEMS] = '{
        total_t'(400), total_t'(500), total_t'(1000), total_t'(2000)
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RETURN = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/vending_controller_if.sv
// ============================================================================
// Module      : vending_controller_if
// Description : Front-panel and actuator signal bundle of the vending controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vending_controller_if;
    import vending_controller_pkg::*;

    logic [C_NUM_COINS-1:0] i_input_coin;
    logic [C_NUM_ITEMS-1:0] i_select_item;
    logic                   i_trigger_return;
    logic [C_NUM_ITEMS-1:0] o_available_item;
    logic [C_NUM_ITEMS-1:0] o_output_item;
    logic [C_NUM_COINS-1:0] o_return_coin;
    total_t                 o_current_total;
    logic                   o_busy;

    modport master (
        output i_input_coin, i_select_item, i_trigger_return,
        input  o_available_item, o_output_item, o_return_coin, o_current_total, o_busy
    );

    modport slave (
        input  i_input_coin, i_select_item, i_trigger_return,
        output o_available_item, o_output_item, o_return_coin, o_current_total, o_busy
    );

endinterface

`default_nettype wire

// File: rtl/vending_controller_change_picker.sv
// ============================================================================
// Module      : vending_controller_change_picker
// Description : Greedy change selector: largest coin not exceeding the balance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vending_controller_change_picker
    import vending_controller_pkg::*;
(
    input  total_t                 i_balance,
    output logic [C_NUM_COINS-1:0] o_coin,
    output logic                   o_done
);

    // Ascending table: the last denomination that fits is the largest one
    always_comb begin
        o_coin = '0;
        for (int k = 0; k < C_NUM_COINS; k++) begin
            if (i_balance >= C_COIN_VALUE[k]) begin
                o_coin    = '0;
                o_coin[k] = 1'b1;
            end
        end
    end

    assign o_done = (i_balance < C_COIN_VALUE[0]);

endmodule

`default_nettype wire

// File: rtl/vending_controller.sv
// ============================================================================
// Module      : vending_controller
// Description : Vending sequencer: coin accumulation, item dispense, inactivity
//               timeout and greedy change return.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vending_controller
    import vending_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100
) (
    input  wire                   clk,
    input  wire                   reset_n,
    vending_controller_if.slave   bus
);

    localparam int C_TIMER_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_TIMER_BITS-1:0] C_TIMER_RELOAD = C_TIMER_BITS'(TIMEOUT_CYCLES);

    state_t                    r_state, w_state_next;
    total_t                    r_balance, w_balance_next;
    logic [C_TIMER_BITS-1:0]   r_timer, w_timer_next;
    logic [C_NUM_ITEMS-1:0]    r_available, w_available_next;
    logic [C_NUM_ITEMS-1:0]    r_output_item, w_output_next;

    logic [C_TOTAL_BITS:0]     w_coin_sum;
    logic [C_TOTAL_BITS:0]     w_sum_wide;
    total_t                    w_balance_sat;
    logic [C_NUM_ITEMS-1:0]    w_sel_mask;
    logic [C_NUM_ITEMS-1:0]    w_sel_onehot;
    total_t                    w_sel_price;
    logic                      w_sel_valid;
    logic                      w_coin_any;
    logic [C_NUM_COINS-1:0]    w_pick_coin;
    logic                      w_pick_done;
    total_t                    w_pick_value;

    vending_controller_change_picker u_change_picker (
        .i_balance (r_balance),
        .o_coin    (w_pick_coin),
        .o_done    (w_pick_done)
    );

    assign w_coin_any = |bus.i_input_coin;

    // Saturating coin accumulation; the extra top bit flags overflow
    always_comb begin
        w_coin_sum = '0;
        for (int k = 0; k < C_NUM_COINS; k++) begin
            if (bus.i_input_coin[k]) begin
                w_coin_sum = w_coin_sum + {1'b0, C_COIN_VALUE[k]};
            end
        end
        w_sum_wide    = {1'b0, r_balance} + w_coin_sum;
        w_balance_sat = w_sum_wide[C_TOTAL_BITS] ? '1 : w_sum_wide[C_TOTAL_BITS-1:0];
    end

    // The registered availability lags the balance by a cycle, so the live
    // balance is also checked to keep a quick second selection from underflowing.
    always_comb begin
        w_sel_onehot = '0;
        w_sel_price  = '0;
        for (int j = 0; j < C_NUM_ITEMS; j++) begin
            w_sel_mask[j] = bus.i_select_item[j] & r_available[j] & (r_balance >= C_PRICE[j]);
        end
        for (int j = C_NUM_ITEMS - 1; j >= 0; j--) begin
            if (w_sel_mask[j]) begin
                w_sel_onehot    = '0;
                w_sel_onehot[j] = 1'b1;
                w_sel_price     = C_PRICE[j];
            end
        end
        w_sel_valid = |w_sel_mask;
    end

    always_comb begin
        w_pick_value = '0;
        for (int k = 0; k < C_NUM_COINS; k++) begin
            if (w_pick_coin[k]) begin
                w_pick_value = C_COIN_VALUE[k];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < C_NUM_ITEMS; j++) begin
            w_available_next[j] = (r_balance >= C_PRICE[j]);
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_balance_next = r_balance;
        w_timer_next   = r_timer;
        w_output_next  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_coin_any) begin
                    w_balance_next = w_balance_sat;
                    w_timer_next   = C_TIMER_RELOAD;
                    w_state_next   = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                w_balance_next = w_balance_sat - w_sel_price;
                w_output_next  = w_sel_onehot;
                if (w_coin_any || w_sel_valid) begin
                    w_timer_next = C_TIMER_RELOAD;
                end else if (r_timer != '0) begin
                    w_timer_next = r_timer - 1'b1;
                end
                if (bus.i_trigger_return) begin
                    w_state_next = ST_RETURN;
                end else if (!w_coin_any && !w_sel_valid && (r_timer == '0)) begin
                    w_state_next = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (w_pick_done) begin
                    w_balance_next = '0;
                    w_timer_next   = C_TIMER_RELOAD;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_balance_next = r_balance - w_pick_value;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_balance     <= '0;
            r_timer       <= C_TIMER_RELOAD;
            r_available   <= '0;
            r_output_item <= '0;
        end else begin
            r_state       <= w_state_next;
            r_balance     <= w_balance_next;
            r_timer       <= w_timer_next;
            r_available   <= w_available_next;
            r_output_item <= w_output_next;
        end
    end

    assign bus.o_available_item = r_available;
    assign bus.o_output_item    = r_output_item;
    assign bus.o_return_coin    = (r_state == ST_RETURN) ? w_pick_coin : '0;
    assign bus.o_current_total  = r_balance;
    assign bus.o_busy           = (r_state == ST_RETURN);

endmodule

`default_nettype wire

// File: tb/tb_vending_controller.sv
// ============================================================================
// Module      : tb_vending_controller
// Description : Directed scoreboard bench for the vending controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vending_controller;
    import vending_controller_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    vending_controller_if bus ();

    vending_controller #(.TIMEOUT_CYCLES(100)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int cyc    = 0;
    int mark   = 0;

    logic [C_NUM_COINS-1:0] coin_q [$];
    logic [C_NUM_ITEMS-1:0] item_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_item(input string tag);
        logic [C_NUM_ITEMS-1:0] exp;
        exp = (item_q.size() != 0) ? item_q.pop_front() : '0;
        check(tag, 32'(bus.o_output_item), 32'(exp));
    endtask

    task automatic wait_busy(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (!bus.o_busy && n < 300) begin
            step();
            n++;
        end
        check(tag, 32'(cyc - mark), 32'(exp_cycles));
    endtask

    task automatic drain_return(input string tag, input int exp_busy, input bit poke);
        int b;
        b = 0;
        while (bus.o_busy && b < 20) begin
            if (bus.o_return_coin != '0) begin
                if (coin_q.size() == 0) check({tag, "_extra"}, 32'(bus.o_return_coin), 32'd0);
                else                    check({tag, "_coin"}, 32'(bus.o_return_coin), 32'(coin_q.pop_front()));
            end
            bus.i_input_coin = (poke && b == 1) ? 3'b100 : 3'b000;
            step();
            b++;
        end
        bus.i_input_coin = '0;
        check({tag, "_busy_cycles"}, 32'(b), 32'(exp_busy));
        check({tag, "_pending"}, 32'(coin_q.size()), 32'd0);
        check({tag, "_total"}, 32'(bus.o_current_total), 32'd0);
    endtask

    initial begin
        bus.i_input_coin     = '0;
        bus.i_select_item    = '0;
        bus.i_trigger_return = 1'b0;

        // Reset state
        step();
        step();
        check("rst_total", 32'(bus.o_current_total), 32'd0);
        check("rst_avail", 32'(bus.o_available_item), 32'd0);
        check("rst_item", 32'(bus.o_output_item), 32'd0);
        check("rst_coin", 32'(bus.o_return_coin), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        reset_n = 1'b1;
        step();

        // Insert 500, availability follows a cycle later
        bus.i_input_coin = 3'b010;
        step();
        bus.i_input_coin = '0;
        check("ins500_total", 32'(bus.o_current_total), 32'd500);
        step();
        check("ins500_avail", 32'(bus.o_available_item), 32'b0011);
        bus.i_input_coin = 3'b010;
        step();
        bus.i_input_coin = '0;
        step();
        check("bal1000_total", 32'(bus.o_current_total), 32'd1000);
        check("bal1000_avail", 32'(bus.o_available_item), 32'b0111);

        // Buy item 0 at 1000
        item_q.push_back(4'b0001);
        bus.i_select_item = 4'b0001;
        step();
        mark = cyc;
        bus.i_select_item = '0;
        check_item("sel0_pulse");
        check("sel0_total", 32'(bus.o_current_total), 32'd600);
        step();
        check_item("sel0_one_cycle");
        check("bal600_avail", 32'(bus.o_available_item), 32'b0011);

        // Unaffordable request: no pulse, no timer reload
        bus.i_select_item = 4'b1100;
        step();
        bus.i_select_item = '0;
        check_item("unaff_pulse");
        check("unaff_total", 32'(bus.o_current_total), 32'd600);
        wait_busy("timeout600_latency", 101);
        coin_q.push_back(3'b010);
        coin_q.push_back(3'b001);
        drain_return("ret600", 3, 1'b0);

        // Return request while idle does nothing
        bus.i_trigger_return = 1'b1;
        step();
        bus.i_trigger_return = 1'b0;
        check("idle_trig_busy", 32'(bus.o_busy), 32'd0);

        // 1600 from three simultaneous coins, then inactivity timeout
        bus.i_input_coin = 3'b111;
        step();
        mark = cyc;
        bus.i_input_coin = '0;
        check("ins1600_total", 32'(bus.o_current_total), 32'd1600);
        wait_busy("timeout1600_latency", 101);
        coin_q.push_back(3'b100);
        coin_q.push_back(3'b010);
        coin_q.push_back(3'b001);
        drain_return("ret1600", 4, 1'b0);

        // 700 with explicit return; a coin poked during RETURN must be ignored
        bus.i_input_coin = 3'b011;
        step();
        bus.i_input_coin = 3'b001;
        step();
        bus.i_input_coin = '0;
        check("bal700_total", 32'(bus.o_current_total), 32'd700);
        bus.i_trigger_return = 1'b1;
        step();
        bus.i_trigger_return = 1'b0;
        coin_q.push_back(3'b010);
        coin_q.push_back(3'b001);
        coin_q.push_back(3'b001);
        drain_return("ret700", 4, 1'b1);

        // Coin and selection together: 1000 + 500 - 1000
        bus.i_input_coin = 3'b100;
        step();
        bus.i_input_coin = '0;
        step();
        item_q.push_back(4'b0100);
        bus.i_input_coin  = 3'b010;
        bus.i_select_item = 4'b0100;
        step();
        bus.i_input_coin  = '0;
        bus.i_select_item = '0;
        check_item("combo_pulse");
        check("combo_total", 32'(bus.o_current_total), 32'd500);
        bus.i_trigger_return = 1'b1;
        step();
        bus.i_trigger_return = 1'b0;
        coin_q.push_back(3'b010);
        drain_return("ret500", 2, 1'b0);

        // Reset in the middle of a payout
        bus.i_input_coin = 3'b111;
        step();
        bus.i_input_coin = '0;
        bus.i_trigger_return = 1'b1;
        step();
        bus.i_trigger_return = 1'b0;
        check("midret_busy", 32'(bus.o_busy), 32'd1);
        check("midret_first", 32'(bus.o_return_coin), 32'b100);
        step();
        check("midret_second", 32'(bus.o_return_coin), 32'b010);
        reset_n = 1'b0;
        step();
        check("midrst_total", 32'(bus.o_current_total), 32'd0);
        check("midrst_busy", 32'(bus.o_busy), 32'd0);
        check("midrst_coin", 32'(bus.o_return_coin), 32'd0);
        check("midrst_item", 32'(bus.o_output_item), 32'd0);
        check("midrst_avail", 32'(bus.o_available_item), 32'd0);
        reset_n = 1'b1;
        step();
        step();
        check("postrst_busy", 32'(bus.o_busy), 32'd0);
        check("postrst_total", 32'(bus.o_current_total), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vending_controller.md
Name: vending_controller

Overview:
- Top-level sequencer for the vending machine.
- Accumulates inserted coin value and advertises affordable items.
- Dispenses one item per accepted selection and runs the inactivity timeout.
- On timeout or explicit return request, pays out change coin-by-coin using the greedy rule.
- Sits between the front-panel inputs and the item/coin actuators. Absorbs the timeout function previously kept in a separate checker.

Parameters:
- TIMEOUT_CYCLES, 100, idle cycles in ACTIVE before automatic change return.
- kNumCoins, 3, number of coin denominations (from shared defs).
- kNumItems, 4, number of items (from shared defs).
- kTotalBits, 31, width of the balance register (from shared defs).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- i_input_coin  input  kNumCoins  bit k set = one coin of denomination k inserted this cycle; multiple bits allowed.
- i_select_item  input  kNumItems  bit j set = item j requested this cycle.
- i_trigger_return  input  1  user change-return request, level-sampled.
- o_available_item  output  kNumItems  bit j = 1 when balance >= price[j]; registered.
- o_output_item  output  kNumItems  one-hot, one-cycle pulse of the dispensed item.
- o_return_coin  output  kNumCoins  one-hot, one-cycle pulse per returned coin.
- o_current_total  output  kTotalBits  current balance.
- o_busy  output  1  high in RETURN; coins and selections are ignored while high.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE, balance=0, timer=TIMEOUT_CYCLES.
  - All outputs 0.
  - Reset overrides any activity, including mid-RETURN; the remaining change is discarded.
- States: IDLE, ACTIVE, RETURN.
- Coin accept (IDLE/ACTIVE):
  - balance += sum of coin_value[k] over set bits, then → ACTIVE.
  - Sum saturates at 2^kTotalBits-1.
  - Timer reloads to TIMEOUT_CYCLES.
- Select (ACTIVE only):
  - j = lowest-index bit of (i_select_item & o_available_item).
  - If j exists: o_output_item[j]=1 next cycle, balance -= price[j], timer reloads.
  - Unavailable selections are ignored and do not reload the timer.
  - Same-cycle coin + select: the select is judged against the pre-coin o_available_item; balance gets +coins -price in one update.
- Timer:
  - Decrements by 1 each cycle in ACTIVE when nothing reloads it.
  - At 0 → RETURN.
  - Does not count in IDLE or RETURN.
- i_trigger_return=1 in ACTIVE → RETURN next cycle, regardless of timer.
- IDLE with i_trigger_return is a no-op.
- RETURN:
  - Each cycle, pick the largest k with coin_value[k] <= balance.
  - Pulse o_return_coin[k] and balance -= coin_value[k].
  - When balance < smallest coin value: residual is forfeited, balance=0, → IDLE, timer reloads.
  - Entering RETURN with balance=0 goes straight to IDLE with no pulse.
  - o_busy=1 for every RETURN cycle.
- o_available_item is recomputed from the registered balance, so it lags a balance update by one cycle.
- Arithmetic is unsigned. Subtraction never underflows because of the availability and greedy guards.

Decomposition:
- Shared defs file (vending_machine_def.v) holds:
  - kNumCoins, kNumItems, kTotalBits;
  - coin_value table (100, 500, 1000);
  - price table (400, 500, 1000, 2000);
  - state encodings (IDLE=0, ACTIVE=1, RETURN=2).
- One sub-module, change_picker: combinational greedy selector. Input is balance; outputs are the one-hot coin and a done flag.

Test Plan:
- Reset, then insert coin bits 3'b010 (500) → next cycle o_current_total=500, o_available_item=4'b0011, state ACTIVE.
- Balance 1000, select 4'b0001 → o_output_item=4'b0001 for one cycle, total=600, timer reloaded to 100.
- Balance 600, select 4'b1100 (unaffordable) → no pulse, total stays 600, timer keeps decrementing.
- Balance 1600 with no activity for 100 cycles → RETURN, pulses 3'b100, 3'b010, 3'b001 on consecutive cycles, then IDLE, total=0.
- Balance 700, i_trigger_return=1 → returns 500 then 100 then 100; o_busy high for 4 cycles; a coin inserted during RETURN is ignored.
- reset_n=0 in the middle of RETURN → next cycle all outputs 0, state IDLE, balance 0.
